fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   IF-stage fetch queue between the PC register and decode. Issues PCF to synchronous
//   instruction memory (1-cycle read), buffers returned words, drives the IF/ID register
//   (instr/pc/pc+4/valid) and back-pressures the PC register through stall_f_o.
//   Absorbs decode stalls without losing in-flight fetches; drops wrong-path work on flush.
// PARAMETERS
//   XLEN      32            datapath / address width
//   DEPTH     2             skid FIFO entries (>=2)
//   NOP_INSTR 32'h00000013  bubble instruction (addi x0,x0,0)
// PORTS
//   clk          in   1     clock, rising edge
//   reset        in   1     reset, synchronous, active-high
//   pcf_i        in   XLEN  current fetch PC from PC register
//   imem_req_o   out  1     read request this cycle
//   imem_addr_o  out  XLEN  read address (= pcf_i)
//   imem_rdata_i in   32    read data; valid the cycle after an accepted request
//   stall_d_i    in   1     decode stall: hold IF/ID outputs
//   flush_d_i    in   1     branch/jump redirect: kill all fetched/in-flight work
//   stall_f_o    out  1     hold PC register
//   instr_d_o    out  32    IF/ID instruction
//   pc_d_o       out  XLEN  IF/ID PC
//   pcplus4_d_o  out  XLEN  IF/ID PC+4
//   valid_d_o    out  1     IF/ID entry is a real instruction
// BEHAVIOUR
//   - State: inflight_v/inflight_pc, FIFO of {pc,instr} (count 0..DEPTH), IF/ID register.
//   - stall_f_o = (count + inflight_v >= DEPTH); function of registered state only.
//   - imem_req_o = !reset & !stall_f_o & !flush_d_i; imem_addr_o = pcf_i always.
//   - inflight_v <= imem_req_o; inflight_pc <= pcf_i when request issued.
//   - Response (inflight_v, no flush) routes: if !stall_d_i & count==0 -> IF/ID directly
//     (bypass); else push to FIFO tail.
//   - IF/ID update when !stall_d_i: FIFO head if count>0 (pop); else bypassed response;
//     else bubble {NOP_INSTR, valid 0, pc/pcplus4 held}. stall_d_i=1: IF/ID holds.
//   - Push+pop same cycle: count unchanged, FIFO order preserved (strict program order).
//   - Latency: PC issued cycle n, empty queue, no stalls -> at IF/ID outputs in cycle n+2.
//     Steady state: one instruction per cycle, stall_f_o=0.
//   - Credit rule guarantees no overflow; push when full is an assertion failure.
//   - flush_d_i (priority over stall_d_i): at next edge count=0, inflight_v=0,
//     IF/ID = {NOP_INSTR, valid 0}; response arriving in flush cycle discarded; no request
//     issued in flush cycle (PCF is wrong-path).
//   - pcplus4 = pc + 4 modulo 2^XLEN (32'hFFFF_FFFC -> 0).
//   - Reset (any cycle, mid-stall included): count=0, inflight_v=0, instr_d_o=NOP_INSTR,
//     pc_d_o=0, pcplus4_d_o=0, valid_d_o=0, stall_f_o=0, imem_req_o=0.
// STRUCTURE
//   - cpu_pkg: XLEN, NOP_INSTR, typedef struct packed {logic [XLEN-1:0] pc; logic [31:0] instr;}
//     fetch_entry_t.
//   - Sub-module fetch_fifo: sync FIFO of fetch_entry_t, DEPTH param, push/pop/flush,
//     count, head; pointer wrap at DEPTH. Remaining control/IF/ID logic in fetch_queue.
// TESTING (bench models PC register: PC<=PC+4 unless stall_f_o; 1-cycle imem, mem[a]=a^32'hA5A5_0000)
//   1 Reset 2 cycles then release, PC from 0 -> valid_d_o first high cycle 2, pc_d_o 0,4,8,...
//     one per cycle, stall_f_o never high.
//   2 stall_d_i high 3 cycles mid-stream -> IF/ID holds, stall_f_o high after count+inflight
//     reaches 2, on release stream resumes with no PC skipped or duplicated.
//   3 flush_d_i one cycle with PC redirected to 0x100 -> next cycle valid_d_o=0, instr NOP;
//     first valid after flush has pc_d_o=0x100, no wrong-path PCs ever valid.
//   4 flush_d_i and stall_d_i both high with FIFO full -> flush wins: count=0, valid_d_o=0,
//     stall_f_o=0 next cycle.
//   5 PC starts at 0xFFFF_FFF8 -> pcplus4_d_o 0xFFFF_FFFC then 0x0000_0000.
//   6 reset asserted while FIFO holds 2 entries and stall active -> all outputs at reset
//     values next cycle, imem_req_o=0 during reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: datapath width, bubble encoding and the fetch entry layout.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a flush that empties it.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok = pop && (count_q != '0);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];

    // Next pointers and occupancy; flush discards everything including a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop_ok) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // The credit scheme upstream must never let a push land on a full FIFO.
    assert property (@(posedge clk) disable iff (reset) !(push && !flush && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_queue.sv
// IF-stage fetch queue: issues PCF to a 1-cycle instruction memory, buffers returned words
// across decode stalls, feeds the IF/ID register and back-pressures the PC register.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pcf_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            stall_d_i,
    input  logic            flush_d_i,
    output logic            stall_f_o,
    output logic [31:0]     instr_d_o,
    output logic [XLEN-1:0] pc_d_o,
    output logic [XLEN-1:0] pcplus4_d_o,
    output logic            valid_d_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic            inflight_v_q;
    logic [XLEN-1:0] inflight_pc_q;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    resp_entry;
    logic            resp_v;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [OW-1:0]   occupancy;

    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;
    logic            valid_q, valid_d;

    // Buffered plus in-flight words; holding the PC at DEPTH guarantees room for every reply.
    assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_v_q};
    assign stall_f_o   = (occupancy >= OW'(DEPTH));
    assign imem_req_o  = !reset && !stall_f_o && !flush_d_i;
    assign imem_addr_o = pcf_i;

    // A reply returning during a redirect belongs to the wrong path and is dropped.
    assign resp_v           = inflight_v_q && !flush_d_i;
    assign resp_entry.pc    = inflight_pc_q;
    assign resp_entry.instr = imem_rdata_i;
    assign bypass           = resp_v && !stall_d_i && (fifo_count == '0);
    assign push             = resp_v && !bypass;
    assign pop              = !flush_d_i && !stall_d_i && (fifo_count != '0);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_d_i),
        .push       (push),
        .push_entry (resp_entry),
        .pop        (pop),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    // Track the single outstanding memory read and the PC it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_v_q <= imem_req_o;
            if (imem_req_o) begin
                inflight_pc_q <= pcf_i;
            end
        end
    end

    // IF/ID next state: flush beats stall; oldest buffered word beats a bypassed reply.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush_d_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_d_i) begin
            if (fifo_count != '0) begin
                instr_d   = fifo_head.instr;
                pc_d      = fifo_head.pc;
                pcplus4_d = fifo_head.pc + XLEN'(4);
                valid_d   = 1'b1;
            end else if (resp_v) begin
                instr_d   = imem_rdata_i;
                pc_d      = inflight_pc_q;
                pcplus4_d = inflight_pc_q + XLEN'(4);
                valid_d   = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    // IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_d_o   = instr_q;
    assign pc_d_o      = pc_q;
    assign pcplus4_d_o = pcplus4_q;
    assign valid_d_o   = valid_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: models the PC register and a 1-cycle memory, records every issued
// PC in program order, and a monitor checks each instruction decode accepts against it.
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcf_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        stall_d_i;
    logic        flush_d_i;
    logic        stall_f_o;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pcplus4_d_o;
    logic        valid_d_o;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [31:0] exp_q [$];
    logic [31:0] pc_cur;
    logic [31:0] start_pc;
    logic        sf_seen;
    logic        backlog_bad;
    logic [31:0] held;
    logic        found;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pcf_i        (pcf_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .stall_d_i    (stall_d_i),
        .flush_d_i    (flush_d_i),
        .stall_f_o    (stall_f_o),
        .instr_d_o    (instr_d_o),
        .pc_d_o       (pc_d_o),
        .pcplus4_d_o  (pcplus4_d_o),
        .valid_d_o    (valid_d_o)
    );

    // Synchronous instruction memory; junk on idle cycles exposes misuse of stale data.
    always @(posedge clk) begin
        imem_rdata_i <= imem_req_o ? (imem_addr_o ^ KEY) : $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock cycle of stimulus; returns mid-cycle so the caller can inspect outputs.
    task automatic cyc(input logic st, input logic fl, input logic rst, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset     = rst;
        stall_d_i = st;
        flush_d_i = fl;
        pcf_i     = pc_cur;
        @(negedge clk);
        #1;
        if (imem_req_o === 1'b1) exp_q.push_back(pcf_i);
        if (fl || rst) exp_q.delete();
        if (stall_f_o === 1'b1) sf_seen = 1'b1;
        if (exp_q.size() > 4) backlog_bad = 1'b1;
        if (rst)                    pc_cur = start_pc;
        else if (fl)                pc_cur = tgt;
        else if (stall_f_o !== 1'b1) pc_cur = pc_cur + 32'd4;
    endtask

    // Monitor: each instruction decode accepts must be the oldest outstanding issued PC.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && valid_d_o === 1'b1 && stall_d_i === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected: pc %h delivered, nothing outstanding", pc_d_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc_d_o, e);
                    check("sb_instr", instr_d_o, e ^ KEY);
                    check("sb_pcplus4", pcplus4_d_o, e + 32'd4);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; stall_d_i = 1'b0; flush_d_i = 1'b0; pcf_i = '0;
        start_pc = '0; pc_cur = '0; sf_seen = 1'b0; backlog_bad = 1'b0;

        // Reset values and first-fetch latency.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("rst_instr", instr_d_o, NOP_INSTR);
        check("rst_pc", pc_d_o, 0);
        check("rst_pcplus4", pcplus4_d_o, 0);
        check("rst_valid", {31'd0, valid_d_o}, 0);
        check("rst_stall_f", {31'd0, stall_f_o}, 0);
        check("rst_req", {31'd0, imem_req_o}, 0);
        sf_seen = 1'b0;
        cyc(0, 0, 0, 0);
        check("c0_req", {31'd0, imem_req_o}, 1);
        check("c0_valid", {31'd0, valid_d_o}, 0);
        cyc(0, 0, 0, 0);
        check("c1_valid", {31'd0, valid_d_o}, 0);
        cyc(0, 0, 0, 0);
        check("c2_valid", {31'd0, valid_d_o}, 1);
        check("c2_pc", pc_d_o, 0);
        repeat (10) cyc(0, 0, 0, 0);
        check("stream_no_stall_f", {31'd0, sf_seen}, 0);

        // Decode stall mid-stream.
        cyc(1, 0, 0, 0);
        held = pc_d_o;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("stall_hold_pc", pc_d_o, held);
        check("stall_f_high", {31'd0, stall_f_o}, 1);
        repeat (8) cyc(0, 0, 0, 0);

        // Redirect to 0x100.
        cyc(0, 1, 0, 32'h100);
        cyc(0, 0, 0, 0);
        check("flush_valid", {31'd0, valid_d_o}, 0);
        check("flush_instr", instr_d_o, NOP_INSTR);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found) begin
                cyc(0, 0, 0, 0);
                if (valid_d_o === 1'b1) begin
                    found = 1'b1;
                    check("flush_first_pc", pc_d_o, 32'h100);
                end
            end
        end
        if (!found) begin
            n_chk++;
            $display("FAIL flush_first_pc: no valid within 6 cycles, expected pc 00000100");
        end
        repeat (4) cyc(0, 0, 0, 0);

        // Flush and stall together with a full FIFO.
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 32'h200);
        cyc(0, 0, 0, 0);
        check("fs_valid", {31'd0, valid_d_o}, 0);
        check("fs_stall_f", {31'd0, stall_f_o}, 0);
        check("fs_instr", instr_d_o, NOP_INSTR);
        check("fs_req", {31'd0, imem_req_o}, 1);
        repeat (6) cyc(0, 0, 0, 0);

        // PC+4 wraps at the top of the address space.
        start_pc = 32'hFFFF_FFF8;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!found) begin
                cyc(0, 0, 0, 0);
                if (valid_d_o === 1'b1) found = 1'b1;
            end
        end
        check("wrap_pc0", pc_d_o, 32'hFFFF_FFF8);
        check("wrap_pcplus4_0", pcplus4_d_o, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0);
        check("wrap_pc1", pc_d_o, 32'hFFFF_FFFC);
        check("wrap_pcplus4_1", pcplus4_d_o, 32'h0000_0000);
        repeat (4) cyc(0, 0, 0, 0);

        // Reset while stalled with a full FIFO.
        start_pc = 32'h40;
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        check("rs_req_in_reset", {31'd0, imem_req_o}, 0);
        cyc(1, 0, 0, 0);
        check("rs_instr", instr_d_o, NOP_INSTR);
        check("rs_pc", pc_d_o, 0);
        check("rs_pcplus4", pcplus4_d_o, 0);
        check("rs_valid", {31'd0, valid_d_o}, 0);
        check("rs_stall_f", {31'd0, stall_f_o}, 0);
        repeat (6) cyc(0, 0, 0, 0);

        // Random stalls, redirects and occasional resets.
        backlog_bad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic        st;
            logic        fl;
            logic        rs;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 99) < 30);
            fl  = ($urandom_range(0, 99) < 5);
            rs  = ($urandom_range(0, 199) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            cyc(st, fl, rs, tgt);
        end
        repeat (6) cyc(0, 0, 0, 0);
        check("backlog_bounded", {31'd0, backlog_bad}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
